// File: rtl/micro_sequencer_if.sv
// Handshake, control-store load and control-word bundle between the micro_sequencer and its surroundings.
// slave = sequencer side, master = host/processing-unit side.
interface micro_sequencer_if #(
  parameter int unsigned ADDR_W = 4
);
  localparam int unsigned WORD_W = 21 + ADDR_W;

  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic              flag_z;
  logic              flag_s;
  logic              flag_v;
  logic              flag_c;
  logic              ucode_we;
  logic [ADDR_W-1:0] ucode_addr;
  logic [WORD_W-1:0] ucode_data;
  logic [2:0]        sel_a;
  logic [2:0]        sel_b;
  logic [2:0]        sel_d;
  logic [3:0]        alu_f;
  logic [2:0]        shf_h;
  logic              reg_we;
  logic              busy;
  logic              done;
  logic [3:0]        status;
  logic [ADDR_W-1:0] upc;

  modport slave (
    input  start, start_addr, flag_z, flag_s, flag_v, flag_c,
    input  ucode_we, ucode_addr, ucode_data,
    output sel_a, sel_b, sel_d, alu_f, shf_h, reg_we,
    output busy, done, status, upc
  );

  modport master (
    output start, start_addr, flag_z, flag_s, flag_v, flag_c,
    output ucode_we, ucode_addr, ucode_data,
    input  sel_a, sel_b, sel_d, alu_f, shf_h, reg_we,
    input  busy, done, status, upc
  );
endinterface

// File: rtl/micro_sequencer.sv
// Microprogrammed control unit: writable control store, flag-latching status register, conditional next-address.
// Optional SINGLE_STEP_EN adds a step input that gates upc/status advance and reg_we.
module micro_sequencer #(
  parameter int unsigned ADDR_W = 4
) (
  input  logic clk,
  input  logic reset,
`ifdef SINGLE_STEP_EN
  input  logic step,
`endif
  micro_sequencer_if.slave bus
);
  localparam int unsigned WORD_W = 21 + ADDR_W;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  localparam logic [2:0] C_SEQ = 3'd0;
  localparam logic [2:0] C_JMP = 3'd1;
  localparam logic [2:0] C_Z   = 3'd2;
  localparam logic [2:0] C_S   = 3'd3;
  localparam logic [2:0] C_V   = 3'd4;
  localparam logic [2:0] C_C   = 3'd5;
  localparam logic [2:0] C_NZ  = 3'd6;
  localparam logic [2:0] C_END = 3'd7;

  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_e;

  typedef struct packed {
    logic [2:0]        sel_a;
    logic [2:0]        sel_b;
    logic [2:0]        sel_d;
    logic [3:0]        alu_f;
    logic [2:0]        shf_h;
    logic              we;
    logic              fl;
    logic [2:0]        cond;
    logic [ADDR_W-1:0] next;
  } uinst_t;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] upc_q, upc_d;
  logic [3:0]        status_q, status_d;
  logic              done_q, done_d;

  logic [WORD_W-1:0] store_q [DEPTH];

  uinst_t            uinst_c;
  logic              advance_c;
  logic              taken_c;
  logic              store_wr_c;

  assign uinst_c    = uinst_t'(store_q[upc_q]);
  assign store_wr_c = bus.ucode_we && (state_q == ST_IDLE) && !reset;

`ifdef SINGLE_STEP_EN
  assign advance_c = step;
`else
  assign advance_c = 1'b1;
`endif

  // Branch decision looks only at the latched status, never at this cycle's flags.
  always_comb begin
    taken_c = 1'b0;
    case (uinst_c.cond)
      C_SEQ:   taken_c = 1'b0;
      C_JMP:   taken_c = 1'b1;
      C_Z:     taken_c = status_q[3];
      C_S:     taken_c = status_q[2];
      C_V:     taken_c = status_q[1];
      C_C:     taken_c = status_q[0];
      C_NZ:    taken_c = !status_q[3];
      default: taken_c = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      upc_q    <= '0;
      status_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      upc_q    <= upc_d;
      status_q <= status_d;
      done_q   <= done_d;
    end
  end

  // Control store keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (store_wr_c) begin
      store_q[bus.ucode_addr] <= bus.ucode_data;
    end
  end

  // Next-state, next-upc and flag latch.
  always_comb begin
    state_d  = state_q;
    upc_d    = upc_q;
    status_d = status_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_RUN;
          upc_d   = bus.start_addr;
        end
      end
      ST_RUN: begin
        if (advance_c) begin
          if (uinst_c.fl) begin
            status_d = {bus.flag_z, bus.flag_s, bus.flag_v, bus.flag_c};
          end
          if (uinst_c.cond == C_END) begin
            state_d = ST_IDLE;
            upc_d   = '0;
            done_d  = 1'b1;
          end else if (taken_c) begin
            upc_d = uinst_c.next;
          end else begin
            upc_d = upc_q + ADDR_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control word is a live copy of store[upc] in RUN; everything is forced low while reset is high.
  always_comb begin
    bus.sel_a  = '0;
    bus.sel_b  = '0;
    bus.sel_d  = '0;
    bus.alu_f  = '0;
    bus.shf_h  = '0;
    bus.reg_we = 1'b0;
    bus.busy   = 1'b0;
    bus.done   = 1'b0;
    bus.status = '0;
    bus.upc    = '0;
    if (!reset) begin
      bus.done   = done_q;
      bus.status = status_q;
      bus.upc    = upc_q;
      if (state_q == ST_RUN) begin
        bus.sel_a  = uinst_c.sel_a;
        bus.sel_b  = uinst_c.sel_b;
        bus.sel_d  = uinst_c.sel_d;
        bus.alu_f  = uinst_c.alu_f;
        bus.shf_h  = uinst_c.shf_h;
        bus.reg_we = uinst_c.we && advance_c;
        bus.busy   = 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_micro_sequencer.sv
// Scoreboard bench for micro_sequencer: each driven cycle pushes its expected outputs, a negedge monitor pops and compares.
module tb_micro_sequencer;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned WORD_W = 21 + ADDR_W;

  typedef struct {
    bit          chk;
    string       tag;
    logic [31:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
`ifdef SINGLE_STEP_EN
  logic step;
`endif

  micro_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

  micro_sequencer #(.ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
`ifdef SINGLE_STEP_EN
    .step  (step),
`endif
    .bus   (bus)
  );

  always #5 clk = ~clk;

  exp_t sb_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // Observed vector: {busy, done, reg_we, sel_a, sel_b, sel_d, alu_f, shf_h, status, upc}
  function automatic logic [31:0] obs();
    return {5'b0, bus.busy, bus.done, bus.reg_we, bus.sel_a, bus.sel_b, bus.sel_d,
            bus.alu_f, bus.shf_h, bus.status, bus.upc};
  endfunction

  function automatic logic [WORD_W-1:0] mk(input int a, input int b, input int d, input int f,
                                           input int h, input int we, input int fl,
                                           input int cond, input int nxt);
    return {3'(a), 3'(b), 3'(d), 4'(f), 3'(h), 1'(we), 1'(fl), 3'(cond), 4'(nxt)};
  endfunction

  function automatic logic [31:0] exp_run(input logic [WORD_W-1:0] w, input int u, input logic [3:0] st);
    return {5'b0, 1'b1, 1'b0, w[8], w[24:9], st, 4'(u)};
  endfunction

  function automatic logic [31:0] exp_idle(input logic dn, input logic [3:0] st);
    return {5'b0, 1'b0, dn, 1'b0, 16'h0, st, 4'h0};
  endfunction

  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      exp_t e;
      e = sb_q.pop_front();
      if (e.chk) check_eq(e.tag, obs(), e.val);
    end
  end

  task automatic cyc(input string tag, input logic [31:0] v);
    exp_t e;
    e.chk = 1'b1; e.tag = tag; e.val = v;
    sb_q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic cyc_skip();
    exp_t e;
    e.chk = 1'b0; e.tag = "skip"; e.val = '0;
    sb_q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic set_flags(input logic [3:0] f);
    {bus.flag_z, bus.flag_s, bus.flag_v, bus.flag_c} = f;
  endtask

  task automatic load(input int a, input logic [WORD_W-1:0] w);
    bus.ucode_we = 1'b1; bus.ucode_addr = 4'(a); bus.ucode_data = w;
    cyc_skip();
    bus.ucode_we = 1'b0;
  endtask

  logic [WORD_W-1:0] w0, w1, w2, w3, w4, w5, w6, w7, w9, w12, w13, w14, w15;
  logic [31:0] v;

  initial begin
    w0  = mk(1, 2, 3, 2, 0, 1, 1, 0, 0);
    w1  = mk(4, 0, 0, 0, 0, 0, 0, 7, 0);
    w2  = mk(5, 5, 5, 1, 1, 0, 1, 0, 0);
    w3  = mk(2, 3, 4, 3, 2, 1, 0, 2, 7);
    w4  = mk(6, 1, 2, 4, 3, 0, 0, 7, 0);
    w5  = mk(3, 3, 3, 5, 4, 1, 1, 2, 9);
    w6  = mk(7, 6, 5, 6, 5, 0, 0, 7, 0);
    w7  = mk(1, 1, 1, 7, 6, 1, 0, 7, 0);
    w9  = mk(2, 2, 2, 8, 7, 0, 0, 7, 0);
    w12 = mk(0, 1, 2, 9, 0, 0, 0, 1, 5);
    w13 = mk(3, 0, 0, 0, 0, 1, 0, 0, 0);
    w14 = mk(0, 0, 1, 0, 0, 0, 0, 7, 0);
    w15 = mk(7, 0, 0, 10, 1, 1, 0, 0, 0);

    reset = 1'b1;
`ifdef SINGLE_STEP_EN
    step = 1'b1;
`endif
    bus.start = 1'b0; bus.start_addr = '0; set_flags(4'b0000);
    bus.ucode_we = 1'b0; bus.ucode_addr = '0; bus.ucode_data = '0;
    @(posedge clk); #1;
    cyc_skip();
    reset = 1'b0;
    cyc("reset_state", exp_idle(1'b0, 4'b0000));

    load(0, w0);  load(1, w1);  load(2, w2);  load(3, w3);  load(4, w4);
    load(5, w5);  load(6, w6);  load(7, w7);  load(9, w9);  load(12, w12);
    load(13, w13); load(14, w14); load(15, w15);

    // Basic program: one ALU word with flag latch, then END.
    bus.start = 1'b1; bus.start_addr = 4'd0;
    cyc("t1_idle", exp_idle(1'b0, 4'b0000));
    bus.start = 1'b0; set_flags(4'b0101);
    cyc("t1_word0", exp_run(w0, 0, 4'b0000));
    set_flags(4'b0000);
    cyc("t1_end", exp_run(w1, 1, 4'b0101));
    cyc("t1_done", exp_idle(1'b1, 4'b0101));
    cyc("t1_after", exp_idle(1'b0, 4'b0101));

    // Branch on z taken; start during RUN is ignored.
    bus.start = 1'b1; bus.start_addr = 4'd2;
    cyc("t2_idle", exp_idle(1'b0, 4'b0101));
    bus.start = 1'b0; set_flags(4'b1000);
    cyc("t2_fl", exp_run(w2, 2, 4'b0101));
    set_flags(4'b0000); bus.start = 1'b1; bus.start_addr = 4'd0;
    cyc("t2_br", exp_run(w3, 3, 4'b1000));
    bus.start = 1'b0;
    cyc("t2_taken", exp_run(w7, 7, 4'b1000));
    cyc("t2_done", exp_idle(1'b1, 4'b1000));

    // Same branch, z clear: falls through to 4.
    bus.start = 1'b1; bus.start_addr = 4'd2;
    cyc("t2b_idle", exp_idle(1'b0, 4'b1000));
    bus.start = 1'b0; set_flags(4'b0000);
    cyc("t2b_fl", exp_run(w2, 2, 4'b1000));
    cyc("t2b_br", exp_run(w3, 3, 4'b0000));
    cyc("t2b_fall", exp_run(w4, 4, 4'b0000));
    cyc("t2b_done", exp_idle(1'b1, 4'b0000));

    // Latch and branch in one word: branch tests the old status.
    bus.start = 1'b1; bus.start_addr = 4'd5;
    cyc("t3_idle", exp_idle(1'b0, 4'b0000));
    bus.start = 1'b0; set_flags(4'b1000);
    cyc("t3_hazard", exp_run(w5, 5, 4'b0000));
    set_flags(4'b0000);
    cyc("t3_next", exp_run(w6, 6, 4'b1000));
    cyc("t3_done", exp_idle(1'b1, 4'b1000));

    // upc wrap 15 -> 0, then start accepted in the done cycle.
    bus.start = 1'b1; bus.start_addr = 4'd15;
    cyc("t4_idle", exp_idle(1'b0, 4'b1000));
    bus.start = 1'b0; set_flags(4'b1111);
    cyc("t4_w15", exp_run(w15, 15, 4'b1000));
    cyc("t4_wrap", exp_run(w0, 0, 4'b1000));
    set_flags(4'b0000);
    cyc("t4_end", exp_run(w1, 1, 4'b1111));
    bus.start = 1'b1; bus.start_addr = 4'd6;
    cyc("t4_done_start", exp_idle(1'b1, 4'b1111));
    bus.start = 1'b0;
    cyc("t4_restart", exp_run(w6, 6, 4'b1111));
    cyc("t4_done2", exp_idle(1'b1, 4'b1111));
    cyc("t4_after", exp_idle(1'b0, 4'b1111));

    // Store write during RUN is dropped; reset at upc=5 aborts without done.
    bus.start = 1'b1; bus.start_addr = 4'd12;
    cyc("t5_idle", exp_idle(1'b0, 4'b1111));
    bus.start = 1'b0;
    bus.ucode_we = 1'b1; bus.ucode_addr = 4'd6; bus.ucode_data = {WORD_W{1'b1}};
    cyc("t5_jump", exp_run(w12, 12, 4'b1111));
    bus.ucode_we = 1'b0; set_flags(4'b1111);
    cyc("t5_at5", exp_run(w5, 5, 4'b1111));
    reset = 1'b1;
    cyc_skip();
    reset = 1'b0; set_flags(4'b0000);
    cyc("t5_rst", exp_idle(1'b0, 4'b0000));
    cyc("t5_nodone", exp_idle(1'b0, 4'b0000));
    bus.start = 1'b1; bus.start_addr = 4'd6;
    cyc("t5_rb_idle", exp_idle(1'b0, 4'b0000));
    bus.start = 1'b0;
    cyc("t5_readback", exp_run(w6, 6, 4'b0000));
    cyc("t5_rb_done", exp_idle(1'b1, 4'b0000));
    cyc("t5_rb_after", exp_idle(1'b0, 4'b0000));

`ifdef SINGLE_STEP_EN
    // Hold then single-step through 13 -> 14(END).
    bus.start = 1'b1; bus.start_addr = 4'd13; step = 1'b0;
    cyc("ss_idle", exp_idle(1'b0, 4'b0000));
    bus.start = 1'b0;
    v = exp_run(w13, 13, 4'b0000); v[24] = 1'b0;
    for (int i = 0; i < 3; i++) cyc("ss_hold", v);
    step = 1'b1;
    cyc("ss_step", exp_run(w13, 13, 4'b0000));
    step = 1'b0;
    cyc("ss_end_hold", exp_run(w14, 14, 4'b0000));
    step = 1'b1;
    cyc("ss_end_step", exp_run(w14, 14, 4'b0000));
    cyc("ss_done", exp_idle(1'b1, 4'b0000));
    cyc("ss_after", exp_idle(1'b0, 4'b0000));
`else
    v = '0;
`endif

    @(posedge clk); #1;
    check_eq("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
